// File: rtl/key_tone_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_tone_pkg
// Brief    : Shared types and helpers for the multi-key tone player.
// Revision : 1.0 - initial release
// ============================================================================
package key_tone_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } tone_state_t;

    // Each key plays one octave above the previous, so its half-period halves.
    function automatic logic [31:0] half_period(input logic [31:0] base,
                                                input logic [2:0]  idx);
        return base >> idx;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] r_idx;
        r_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) r_idx = 3'(i);
        end
        return r_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_ch
// Brief    : One key channel: 2-FF synchronizer, debounce counter, press pulse.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_tone_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_raw,
    output logic key_stable,
    output logic key_press
);

    localparam int C_CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_stable_d;
    logic               r_press;
    logic [C_CNT_W-1:0] r_cnt;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= key_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_press    <= r_stable_d & ~r_stable;
            // Any return to the accepted level restarts the stability window.
            if (r_sync2 != r_stable) begin
                if (r_cnt == C_CNT_W'(DEBOUNCE_CYC - 1)) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign key_stable = r_stable;
    assign key_press  = r_press;

endmodule
`default_nettype wire

// File: rtl/key_tone_player.sv
`default_nettype none
// ============================================================================
// Module   : key_tone_player
// Brief    : Debounced multi-key buzzer driver with one-shot or hold tones.
// Revision : 1.0 - initial release
// ============================================================================
module key_tone_player
    import key_tone_pkg::*;
#(
    parameter  int KEY_NUM      = 4,
    parameter  int DEBOUNCE_CYC = 1000000,
    parameter  int BASE_HALF    = 95556,
    parameter  int BEEP_CYC     = 10000000,
    parameter  int HOLD_MODE    = 0,
    localparam int TI_W         = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key,
    input  logic               mute,
    output logic               beep,
    output logic [KEY_NUM-1:0] key_state,
    output logic               busy,
    output logic [TI_W-1:0]    tone_idx
);

    localparam int C_HALF_W = (BASE_HALF > 1) ? $clog2(BASE_HALF) : 1;
    localparam int C_DUR_W  = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;

    if (KEY_NUM < 1 || KEY_NUM > 8) begin : g_bad_key_num
        $error("key_tone_player: KEY_NUM must be 1..8");
    end
    if ((BASE_HALF >> (KEY_NUM - 1)) < 1) begin : g_bad_base_half
        $error("key_tone_player: BASE_HALF too small for highest key");
    end

    logic [KEY_NUM-1:0] w_key_state;
    logic [KEY_NUM-1:0] w_press;

    for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
        key_debounce_ch #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key_raw   (key[gi]),
            .key_stable(w_key_state[gi]),
            .key_press (w_press[gi])
        );
    end

    tone_state_t         r_state;
    logic [TI_W-1:0]     r_tone_idx;
    logic [C_DUR_W-1:0]  r_dur_cnt;
    logic [C_HALF_W-1:0] r_half_cnt;
    logic                r_wave;
    logic                r_beep;
    logic                r_busy;

    logic                w_any_press;
    logic [TI_W-1:0]     w_sel_idx;
    logic [C_HALF_W-1:0] w_half_max;
    logic                w_half_wrap;
    logic                w_wave_next;
    logic                w_exit;

    assign w_any_press = |w_press;
    assign w_sel_idx   = TI_W'(lowest_set(8'(w_press)));
    assign w_half_max  = C_HALF_W'(half_period(32'(BASE_HALF), 3'(r_tone_idx)) - 32'd1);
    assign w_half_wrap = (r_half_cnt == w_half_max);
    assign w_wave_next = w_half_wrap ? ~r_wave : r_wave;
    assign w_exit      = (HOLD_MODE == 0) ? (r_dur_cnt == '0) : w_key_state[r_tone_idx];

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_tone_idx <= '0;
            r_dur_cnt  <= '0;
            r_half_cnt <= '0;
            r_wave     <= 1'b0;
            r_beep     <= 1'b0;
            r_busy     <= 1'b0;
        end else if (w_any_press) begin
            // A fresh press starts (or restarts) a tone and beats any expiry.
            r_state    <= ST_PLAY;
            r_tone_idx <= w_sel_idx;
            r_dur_cnt  <= C_DUR_W'(BEEP_CYC - 1);
            r_half_cnt <= '0;
            r_wave     <= 1'b0;
            r_beep     <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (w_exit) begin
                        r_state    <= ST_IDLE;
                        r_half_cnt <= '0;
                        r_wave     <= 1'b0;
                        r_beep     <= 1'b0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_half_cnt <= w_half_wrap ? '0 : r_half_cnt + C_HALF_W'(1);
                        r_wave     <= w_wave_next;
                        r_beep     <= w_wave_next & ~mute;
                        if (HOLD_MODE == 0) r_dur_cnt <= r_dur_cnt - C_DUR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_beep  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign beep      = r_beep;
    assign busy      = r_busy;
    assign tone_idx  = r_tone_idx;
    assign key_state = w_key_state;

endmodule
`default_nettype wire

// File: tb/tb_key_tone_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_tone_player
// Brief    : Randomised self-checking bench for one-shot and hold tone players.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_tone_player;

    localparam int D  = 8;
    localparam int BH = 16;
    localparam int BC = 200;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       mute;
    logic [3:0] key;
    logic       beep0, busy0, beep1, busy1;
    logic [3:0] ks0, ks1;
    logic [1:0] idx0, idx1;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    key_tone_player #(.KEY_NUM(4), .DEBOUNCE_CYC(D), .BASE_HALF(BH),
                      .BEEP_CYC(BC), .HOLD_MODE(0)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key), .mute(mute),
        .beep(beep0), .key_state(ks0), .busy(busy0), .tone_idx(idx0));

    key_tone_player #(.KEY_NUM(4), .DEBOUNCE_CYC(D), .BASE_HALF(BH),
                      .BEEP_CYC(BC), .HOLD_MODE(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key), .mute(mute),
        .beep(beep1), .key_state(ks1), .busy(busy1), .tone_idx(idx1));

    // Reference: key levels from run lengths of the synchronised input, tone
    // shape from elapsed time since the tone started.
    int         t = 0;
    logic [3:0] m_s1, m_s2, m_stable;
    int         m_run  [4];
    int         m_fall [4];
    logic       m_busy [2];
    logic       m_beep [2];
    logic [1:0] m_idx  [2];
    int         m_start[2];

    task automatic model_step();
        logic [3:0] pressed;
        int         el;
        logic       ex;
        if (!sys_rst_n) begin
            m_s1 = '1; m_s2 = '1; m_stable = '1;
            for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_fall[i] = -100; end
            for (int h = 0; h < 2; h++) begin
                m_busy[h] = 0; m_beep[h] = 0; m_idx[h] = 0; m_start[h] = 0;
            end
            t++;
            return;
        end
        pressed = '0;
        for (int i = 0; i < 4; i++) if (m_fall[i] == t - 2) pressed[i] = 1'b1;
        for (int h = 0; h < 2; h++) begin
            if (pressed != 0) begin
                for (int i = 3; i >= 0; i--) if (pressed[i]) m_idx[h] = 2'(i);
                m_start[h] = t; m_busy[h] = 1; m_beep[h] = 0;
            end else if (m_busy[h]) begin
                el = t - m_start[h];
                ex = (h == 0) ? (el >= BC) : m_stable[m_idx[h]];
                if (ex) begin
                    m_busy[h] = 0; m_beep[h] = 0;
                end else begin
                    m_beep[h] = ((el / (BH >> m_idx[h])) % 2 == 1) && !mute;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_stable[i] = m_s2[i];
                    m_run[i] = 0;
                    if (!m_stable[i]) m_fall[i] = t;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = key;
        t++;
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) cycle();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        checks++; if (beep0 !== 1'b0) begin errors++; $display("FAIL reset_beep got=%b exp=0", beep0); end
        checks++; if (ks0 !== 4'hF) begin errors++; $display("FAIL reset_key_state got=%h exp=f", ks0); end
        checks++; if (idx0 !== 2'd0) begin errors++; $display("FAIL reset_tone_idx got=%0d exp=0", idx0); end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_single();
        int rise = -1, fall = -1, rises = 0, exp_rises = 0;
        logic pb = 1'b0;
        for (int k = 0; BH * (2 * k + 1) < BC; k++) exp_rises++;
        key = 4'b1110;
        for (int c = 1; c <= 300; c++) begin
            cycle();
            checks++;
            if ({beep0, busy0, idx0, ks0} !== {m_beep[0], m_busy[0], m_idx[0], m_stable}) begin
                errors++; $display("FAIL single_h0 c=%0d got=%b exp=%b", c, {beep0, busy0, idx0, ks0}, {m_beep[0], m_busy[0], m_idx[0], m_stable});
            end
            checks++;
            if ({beep1, busy1, idx1} !== {m_beep[1], m_busy[1], m_idx[1]}) begin
                errors++; $display("FAIL single_h1 c=%0d got=%b exp=%b", c, {beep1, busy1, idx1}, {m_beep[1], m_busy[1], m_idx[1]});
            end
            if (c == 20) key = 4'hF;
            if (busy0 && rise < 0) rise = c;
            if (!busy0 && rise >= 0 && fall < 0) begin
                fall = c;
                checks++; if (beep0 !== 1'b0) begin errors++; $display("FAIL single_beep_at_end got=%b exp=0", beep0); end
            end
            if (busy0 && beep0 && !pb) rises++;
            pb = beep0;
        end
        checks++; if (rise != 1 + D + 3) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", rise, 1 + D + 3); end
        checks++; if (fall - rise != BC) begin errors++; $display("FAIL single_duration got=%0d exp=%0d", fall - rise, BC); end
        checks++; if (rises != exp_rises) begin errors++; $display("FAIL single_beep_rises got=%0d exp=%0d", rises, exp_rises); end
    endtask

    // Drives a key pattern, counts tone starts and measures the first half-period.
    task automatic test_pitch(input string name, input logic [3:0] pat_a,
                              input int len_a, input int len_gap, input int len_b,
                              input logic [1:0] exp_idx);
        int starts = 0, t_up = -1, t_dn = -1;
        logic pb = 1'b0, pbusy = 1'b0;
        for (int c = 1; c <= 260; c++) begin
            if (c <= len_a) key = pat_a;
            else if (c <= len_a + len_gap) key = 4'hF;
            else if (c <= len_a + len_gap + len_b) key = pat_a;
            else key = 4'hF;
            cycle();
            checks++;
            if ({beep0, busy0, idx0, ks0} !== {m_beep[0], m_busy[0], m_idx[0], m_stable}) begin
                errors++; $display("FAIL %s_h0 c=%0d got=%b exp=%b", name, c, {beep0, busy0, idx0, ks0}, {m_beep[0], m_busy[0], m_idx[0], m_stable});
            end
            checks++;
            if ({beep1, busy1, idx1} !== {m_beep[1], m_busy[1], m_idx[1]}) begin
                errors++; $display("FAIL %s_h1 c=%0d got=%b exp=%b", name, c, {beep1, busy1, idx1}, {m_beep[1], m_busy[1], m_idx[1]});
            end
            if (busy0 && !pbusy) starts++;
            if (beep0 && !pb && t_up < 0) t_up = c;
            if (!beep0 && pb && t_up >= 0 && t_dn < 0) t_dn = c;
            pb = beep0; pbusy = busy0;
        end
        checks++; if (starts != 1) begin errors++; $display("FAIL %s_starts got=%0d exp=1", name, starts); end
        checks++; if (idx0 !== exp_idx) begin errors++; $display("FAIL %s_idx got=%0d exp=%0d", name, idx0, exp_idx); end
        checks++; if (t_dn - t_up != (BH >> exp_idx)) begin errors++; $display("FAIL %s_half got=%0d exp=%0d", name, t_dn - t_up, BH >> exp_idx); end
    endtask

    task automatic test_retrigger();
        int rise = -1, blen = 0;
        key = 4'b0111;
        for (int c = 1; c <= 400; c++) begin
            cycle();
            checks++;
            if ({beep0, busy0, idx0, ks0} !== {m_beep[0], m_busy[0], m_idx[0], m_stable}) begin
                errors++; $display("FAIL retrig_h0 c=%0d got=%b exp=%b", c, {beep0, busy0, idx0, ks0}, {m_beep[0], m_busy[0], m_idx[0], m_stable});
            end
            checks++;
            if ({beep1, busy1, idx1} !== {m_beep[1], m_busy[1], m_idx[1]}) begin
                errors++; $display("FAIL retrig_h1 c=%0d got=%b exp=%b", c, {beep1, busy1, idx1}, {m_beep[1], m_busy[1], m_idx[1]});
            end
            if (busy0 && rise < 0) rise = c;
            if (busy0) blen++;
            if (c == 20) key[3] = 1'b1;
            if (rise >= 0 && c == rise + 88) key[0] = 1'b0;
            if (rise >= 0 && c == rise + 108) key[0] = 1'b1;
        end
        checks++; if (blen != 100 + BC) begin errors++; $display("FAIL retrig_busy_len got=%0d exp=%0d", blen, 100 + BC); end
        checks++; if (idx0 !== 2'd0) begin errors++; $display("FAIL retrig_idx got=%0d exp=0", idx0); end
    endtask

    task automatic test_hold_mute();
        key = 4'b1101;
        for (int c = 1; c <= 620; c++) begin
            mute = (c >= 200 && c < 260);
            if (c > 500) key = 4'hF;
            cycle();
            checks++;
            if ({beep1, busy1, idx1, ks1} !== {m_beep[1], m_busy[1], m_idx[1], m_stable}) begin
                errors++; $display("FAIL hold_h1 c=%0d got=%b exp=%b", c, {beep1, busy1, idx1, ks1}, {m_beep[1], m_busy[1], m_idx[1], m_stable});
            end
            checks++;
            if ({beep0, busy0, idx0} !== {m_beep[0], m_busy[0], m_idx[0]}) begin
                errors++; $display("FAIL hold_h0 c=%0d got=%b exp=%b", c, {beep0, busy0, idx0}, {m_beep[0], m_busy[0], m_idx[0]});
            end
            if (c == 230) begin
                checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL mute_busy got=%b exp=1", busy1); end
                checks++; if (beep1 !== 1'b0) begin errors++; $display("FAIL mute_beep got=%b exp=0", beep1); end
            end
            if (c == 480) begin
                checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL hold_persist got=%b exp=1", busy1); end
            end
        end
        mute = 1'b0;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", busy1); end
    endtask

    task automatic test_reset_mid();
        int rise = -1;
        key = 4'b1110;
        for (int c = 1; c <= 400; c++) begin
            sys_rst_n = !(rise >= 0 && c == rise + 50);
            if (c == 120) key = 4'hF;
            cycle();
            if (!sys_rst_n) begin
                checks++;
                if ({beep0, busy0, idx0, ks0, beep1, busy1} !== {1'b0, 1'b0, 2'd0, 4'hF, 1'b0, 1'b0}) begin
                    errors++; $display("FAIL reset_mid got=%b exp=%b", {beep0, busy0, idx0, ks0, beep1, busy1}, {1'b0, 1'b0, 2'd0, 4'hF, 1'b0, 1'b0});
                end
            end else begin
                checks++;
                if ({beep0, busy0, idx0, ks0, beep1, busy1} !== {m_beep[0], m_busy[0], m_idx[0], m_stable, m_beep[1], m_busy[1]}) begin
                    errors++; $display("FAIL reset_mid_model c=%0d got=%b exp=%b", c, {beep0, busy0, idx0, ks0, beep1, busy1}, {m_beep[0], m_busy[0], m_idx[0], m_stable, m_beep[1], m_busy[1]});
                end
            end
            if (busy0 && rise < 0) rise = c;
        end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int s = 0; s < 150; s++) begin
            int len = $urandom_range(1, 30);
            key  = 4'($urandom_range(0, 15));
            mute = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < len; c++) begin
                cycle();
                checks++;
                if ({beep0, busy0, idx0, ks0} !== {m_beep[0], m_busy[0], m_idx[0], m_stable}) begin
                    errors++; $display("FAIL random_h0 t=%0d got=%b exp=%b", t, {beep0, busy0, idx0, ks0}, {m_beep[0], m_busy[0], m_idx[0], m_stable});
                end
                checks++;
                if ({beep1, busy1, idx1, ks1} !== {m_beep[1], m_busy[1], m_idx[1], m_stable}) begin
                    errors++; $display("FAIL random_h1 t=%0d got=%b exp=%b", t, {beep1, busy1, idx1, ks1}, {m_beep[1], m_busy[1], m_idx[1], m_stable});
                end
            end
        end
        key = 4'hF; mute = 1'b0;
    endtask

    initial begin
        key = 4'hF; mute = 1'b0; sys_rst_n = 1'b0;
        @(negedge sys_clk);
        test_reset();
        test_single();
        test_pitch("bounce", 4'b1101, 5, 2, 20, 2'd1);
        test_pitch("simul", 4'b0011, 20, 0, 0, 2'd2);
        test_retrigger();
        test_hold_mute();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0d", t);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/key_tone_player.md
Name: key_tone_player

Overview:
- Multi-key, multi-tone successor to the single-key debounce/beep pair.
- Debounces KEY_NUM active-low push-buttons.
- Each debounced press starts a square-wave tone on a passive buzzer. Key i selects octave i of a base tone.
- Supports one-shot (fixed duration) and hold (sound while pressed) modes, retrigger, and a mute input; sits directly between board keys and the buzzer pin.

Parameters:
- KEY_NUM, 4, number of keys/tones (1..8).
- DEBOUNCE_CYC, 1000000, stable cycles before a key level is accepted (20 ms @ 50 MHz).
- BASE_HALF, 95556, half-period in clocks of key 0 tone (≈261.6 Hz @ 50 MHz); key i half-period = BASE_HALF >> i.
- BEEP_CYC, 10000000, one-shot tone length in clocks (200 ms).
- HOLD_MODE, 0, 0 = one-shot for BEEP_CYC; 1 = tone lasts while the selecting key stays pressed.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, synchronous, active-low.
- key  in  KEY_NUM  raw keys, 0 = pressed, asynchronous.
- mute  in  1  1 forces beep low; FSM keeps running.
- beep  out  1  buzzer drive, square wave.
- key_state  out  KEY_NUM  debounced levels, 1 = released.
- busy  out  1  1 while in PLAY.
- tone_idx  out  $clog2(KEY_NUM) or 1  index of key being played.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - Sync flops and key_state go to all 1s.
  - Debounce counters reset to 0.
  - FSM goes to IDLE; beep=0, busy=0, tone_idx=0; all counters 0.
  - Reset mid-tone aborts immediately; there is no resume.
- Per-key debounce, one channel per key:
  - 2-FF synchronizer.
  - Counter increments while synced != stable and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC-1 with synced still != stable: stable <= synced and the counter clears.
  - Any bounce resets the count.
  - press[i] is a 1-cycle pulse on a stable 1->0 transition.
  - Latency: press[i] is asserted DEBOUNCE_CYC+2 cycles after the first clock edge sampling raw key low, provided the key stays low.
  - Release produces no pulse.
- FSM states:
  - IDLE: on any press[i], select the lowest pressed index s. Then latch tone_idx=s, load dur_cnt=BEEP_CYC-1, half_cnt=0, beep=0, and go to PLAY.
  - PLAY, every cycle:
    - half_cnt counts up; at (BASE_HALF>>tone_idx)-1 it clears and the internal wave toggles.
    - beep = wave & ~mute.
    - If HOLD_MODE=0: dur_cnt decrements; the cycle it is 0, go to IDLE.
    - If HOLD_MODE=1: exit when key_state[tone_idx] returns to 1.
  - Retrigger in PLAY: a new press (lowest index if several) reloads tone_idx, dur_cnt and half_cnt and clears the wave. A new press has priority over a same-cycle expiry.
  - On entry to IDLE, beep and the wave are 0 in the same cycle.
- busy = (state==PLAY), registered.
- Widths: counters use $clog2 of their maxima; BASE_HALF>>i must be ≥1 (elaboration check); no wrap-around is possible.

Decomposition:
- Package key_tone_pkg:
  - FSM state enum (IDLE, PLAY).
  - Function half_period(idx) returning BASE_HALF>>idx.
  - Function lowest_set(vec) priority encoder.
- Sub-module key_debounce_ch: single-channel sync + debounce, outputs a stable level and a press pulse, generated KEY_NUM times.
- Top holds the FSM, tone divider and duration counter.

Test Plan (bench: DEBOUNCE_CYC=8, BASE_HALF=16, BEEP_CYC=200, KEY_NUM=4):
- Hold key[0] low 20 cycles -> press pulse 10 cycles after the first low sample; busy=1 next cycle; beep toggles every 16 cycles; busy falls after 200 cycles with beep=0.
- Bounce on key[1] (low 5, high 2, low 20) -> exactly one press; tone half-period 8; key_state[1]=0 only after 8 stable cycles.
- key[2] and key[3] pressed in the same cycle -> tone_idx=2, half-period 4.
- key[0] pressed at cycle 100 of a key[3] tone -> tone_idx=0, dur_cnt reloaded; total busy ≈300 cycles.
- HOLD_MODE=1: hold key[1] 500 cycles -> tone persists until debounced release; mute=1 mid-tone -> beep 0 while busy stays 1.
- sys_rst_n=0 for 1 cycle mid-tone -> next cycle beep=0, busy=0, key_state=4'hF.
